// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the iterative divider.
package div_pkg;
  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
endpackage

// File: rtl/div_if.sv
// Request/result bundle between the pipeline and the divider.
interface div_if;
  import div_pkg::*;

  logic             start;
  logic             is_signed;
  logic             flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] HI;
  logic [CNT_W-1:0] counter;

  modport master (
    output start, is_signed, flush, A, B,
    input  busy, done, div0, LO, HI, counter
  );

  modport slave (
    input  start, is_signed, flush, A, B,
    output busy, done, div0, LO, HI, counter
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration, purely combinational.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dividend_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the 33-bit trial's top bit is exactly the borrow.
  always_comb begin
    shifted       = {rem, dividend[WIDTH-1]};
    trial         = shifted - {1'b0, divisor};
    rem_next      = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    dividend_next = {dividend[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider: latch, take magnitudes, 32 restoring
// steps, then sign-fix into HI/LO.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER_COUNT - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH-1:0] rem_step, dvd_step;
  logic [CNT_W-1:0] cnt;
  logic             sgn, neg_q, neg_r;
  logic             done_q, div0_q;
  logic             accept, zero_req, abort;

  div_step u_step (
    .rem           (rem),
    .dividend      (dvd),
    .divisor       (dvs),
    .rem_next      (rem_step),
    .dividend_next (dvd_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // flush suppresses start in IDLE and aborts any in-flight state.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    zero_req   = 1'b0;
    abort      = (state != IDLE) && bus.flush;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.B == '0) begin
            zero_req = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = PREP;
          end
        end
      end
      PREP: state_next = ITER;
      ITER: if (cnt == LAST_STEP) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      lo     <= '0;
      hi     <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      if (abort) begin
        cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              dvd <= bus.A;
              dvs <= bus.B;
              sgn <= bus.is_signed;
            end else if (zero_req) begin
              done_q <= 1'b1;
              div0_q <= 1'b1;
            end
          end
          PREP: begin
            if (sgn && dvd[WIDTH-1]) dvd <= '0 - dvd;
            if (sgn && dvs[WIDTH-1]) dvs <= '0 - dvs;
            neg_q <= sgn && (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
            neg_r <= sgn && dvd[WIDTH-1];
            rem   <= '0;
            cnt   <= '0;
          end
          ITER: begin
            rem <= rem_step;
            dvd <= dvd_step;
            cnt <= cnt + CNT_W'(1);
          end
          FIX: begin
            lo     <= neg_q ? ('0 - dvd) : dvd;
            hi     <= neg_r ? ('0 - rem) : rem;
            done_q <= 1'b1;
            cnt    <= '0;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.div0    = div0_q;
  assign bus.LO      = lo;
  assign bus.HI      = hi;
  assign bus.counter = cnt;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, div-by-zero,
// flush and async reset aborts, busy-start rejection and back-to-back start.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   assertions = 0;
  int   failures   = 0;
  int   lat, bc, last_cnt, pulses, guard;

  div_if bus ();

  div_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.A         = a;
    bus.B         = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  // Counts edges until done (bounded), busy samples, and the counter one edge before done.
  task automatic wait_done(output int l, output int b, output int c);
    l = 0;
    b = 0;
    c = 0;
    while (!bus.done && l < 100) begin
      if (bus.busy) b++;
      c = int'(bus.counter);
      tick();
      l++;
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.flush     = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    reset         = 1'b1;
    #3;
    check("rst_LO",      bus.LO, 32'h0);
    check("rst_HI",      bus.HI, 32'h0);
    check("rst_busy",    32'(bus.busy), 32'h0);
    check("rst_done",    32'(bus.done), 32'h0);
    check("rst_div0",    32'(bus.div0), 32'h0);
    check("rst_counter", 32'(bus.counter), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Unsigned 100/7 with full timing.
    start_div(32'd100, 32'd7, 1'b0);
    check("u100_busy_e0", 32'(bus.busy), 32'h1);
    wait_done(lat, bc, last_cnt);
    check("u100_latency",  lat, 34);
    check("u100_busycyc",  bc, 34);
    check("u100_cnt_e33",  last_cnt, 32);
    check("u100_cnt_done", 32'(bus.counter), 32'h0);
    check("u100_busy_dn",  32'(bus.busy), 32'h0);
    check("u100_div0",     32'(bus.div0), 32'h0);
    check("u100_LO",       bus.LO, 32'd14);
    check("u100_HI",       bus.HI, 32'd2);
    tick();
    check("u100_done_pulse", 32'(bus.done), 32'h0);

    start_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(lat, bc, last_cnt);
    check("s_m7_latency", lat, 34);
    check("s_m7_LO", bus.LO, 32'hFFFF_FFFD);
    check("s_m7_HI", bus.HI, 32'hFFFF_FFFF);

    start_div(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(lat, bc, last_cnt);
    check("u_m7_LO", bus.LO, 32'h7FFF_FFFC);
    check("u_m7_HI", bus.HI, 32'h1);

    start_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bc, last_cnt);
    check("ovf_LO",   bus.LO, 32'h8000_0000);
    check("ovf_HI",   bus.HI, 32'h0);
    check("ovf_div0", 32'(bus.div0), 32'h0);

    // Divide by zero leaves HI/LO at the previous 23/4 result.
    start_div(32'd23, 32'd4, 1'b0);
    wait_done(lat, bc, last_cnt);
    check("u23_LO", bus.LO, 32'd5);
    check("u23_HI", bus.HI, 32'd3);
    tick();
    start_div(32'd9, 32'd0, 1'b0);
    check("dz_done", 32'(bus.done), 32'h1);
    check("dz_div0", 32'(bus.div0), 32'h1);
    check("dz_busy", 32'(bus.busy), 32'h0);
    check("dz_LO",   bus.LO, 32'd5);
    check("dz_HI",   bus.HI, 32'd3);
    tick();
    check("dz_done_clr", 32'(bus.done), 32'h0);
    check("dz_div0_clr", 32'(bus.div0), 32'h0);
    check("dz_busy_after", 32'(bus.busy), 32'h0);

    // Flush at counter 10.
    start_div(32'd1000, 32'd3, 1'b0);
    guard = 0;
    while (bus.counter != 6'd10 && guard < 50) begin
      tick();
      guard++;
    end
    check("fl_cnt10", 32'(bus.counter), 32'd10);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_busy", 32'(bus.busy), 32'h0);
    check("fl_cnt",  32'(bus.counter), 32'h0);
    check("fl_done", 32'(bus.done), 32'h0);
    check("fl_LO",   bus.LO, 32'd5);
    check("fl_HI",   bus.HI, 32'd3);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("fl_no_done", pulses, 0);
    start_div(32'd1000, 32'd3, 1'b0);
    wait_done(lat, bc, last_cnt);
    check("fl_re_lat", lat, 34);
    check("fl_re_LO",  bus.LO, 32'd333);
    check("fl_re_HI",  bus.HI, 32'd1);

    // Async reset between clock edges mid-ITER.
    start_div(32'd50, 32'd5, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    #3 reset = 1'b1;
    #1;
    check("ar_LO",   bus.LO, 32'h0);
    check("ar_HI",   bus.HI, 32'h0);
    check("ar_busy", 32'(bus.busy), 32'h0);
    check("ar_cnt",  32'(bus.counter), 32'h0);
    check("ar_done", 32'(bus.done), 32'h0);
    #2 reset = 1'b0;
    tick();
    check("ar_idle", 32'(bus.busy), 32'h0);
    start_div(32'd52, 32'hFFFF_FFFB, 1'b1);
    wait_done(lat, bc, last_cnt);
    check("ar_re_lat", lat, 34);
    check("ar_re_LO",  bus.LO, 32'hFFFF_FFF6);
    check("ar_re_HI",  bus.HI, 32'd2);

    // Start during busy is ignored; start on the done cycle is accepted.
    tick();
    start_div(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat, bc, last_cnt);
    check("bz_lat", lat, 29);
    check("bz_LO",  bus.LO, 32'd14);
    check("bz_HI",  bus.HI, 32'd2);
    start_div(32'd200, 32'd9, 1'b0);
    check("b2b_busy", 32'(bus.busy), 32'h1);
    wait_done(lat, bc, last_cnt);
    check("b2b_lat", lat, 34);
    check("b2b_LO",  bus.LO, 32'd22);
    check("b2b_HI",  bus.HI, 32'd2);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy) pulses++;
    end
    check("b2b_no_queue", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; the only supported value is 32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
REQ-006 Port: flush  input  1  synchronous abort of an in-flight division.
REQ-007 Port: A  input  32  dividend; sampled with start.
REQ-008 Port: B  input  32  divisor; sampled with start.
REQ-009 Port: busy  output  1  high while a division is in flight (pipeline stall).
REQ-010 Port: done  output  1  one-cycle pulse: result or div0 is valid.
REQ-011 Port: div0  output  1  one-cycle pulse with done when B was zero.
REQ-012 Port: LO  output  32  quotient register.
REQ-013 Port: HI  output  32  remainder register.
REQ-014 Port: counter  output  6  iteration count, 0..32.

Function
REQ-015 FSM states: IDLE, PREP, ITER, FIX.
REQ-016 IDLE, start=1, B!=0: latch operands and is_signed, go to PREP; busy rises after this edge (edge 0).
REQ-017 IDLE, start=1, B==0: stay in IDLE; done=1 and div0=1 for one cycle after edge 0; HI/LO unchanged; busy stays 0.
REQ-018 PREP (edge 1): if is_signed, replace negative operands with their magnitudes (0 - x); record neg_q = sign(A) XOR sign(B) and neg_r = sign(A); clear remainder accumulator; set counter=0; go to ITER.
REQ-019 ITER: one restoring shift-subtract step per cycle.
  - Shift {rem, dividend} left by 1.
  - Trial = rem - divisor.
  - If trial is non-negative: rem = trial and quotient bit = 1; else keep rem and quotient bit = 0.
  - counter increments by 1 each step.
REQ-020 After the 32nd ITER edge (edge 33, counter=32), go to FIX.
REQ-021 FIX (edge 34) writes the results and returns to IDLE.
  - LO = neg_q ? 0 - quotient : quotient.
  - HI = neg_r ? 0 - rem : rem.
  - done=1 for one cycle; busy falls; counter returns to 0.
REQ-022 Latency: done is visible 34 cycles after the start edge; back-to-back start is accepted on the cycle done is high.
REQ-023 start while busy is ignored and not queued.
REQ-024 flush=1 in PREP/ITER/FIX: next edge goes to IDLE; counter=0; no done; HI/LO unchanged. flush in IDLE has no effect, and flush wins over start.
REQ-025 Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (modulo-2^32 result); no flag is raised.
REQ-026 HI/LO change only in FIX, so they hold the last result indefinitely.
REQ-027 All arithmetic is 32-bit modulo 2^32, except the trial subtract, which is 33-bit so its sign bit is the borrow.

Reset
REQ-028 reset=1 immediately forces the following, regardless of clk:
  - state=IDLE;
  - busy=0, done=0, div0=0;
  - LO=0, HI=0, counter=0;
  - all internal registers cleared.
REQ-029 reset mid-operation discards the division; no done is produced.

Structure
REQ-030 Shared package div_pkg: WIDTH constant, state enum type {IDLE, PREP, ITER, FIX}, ITER_COUNT=32 constant.
REQ-031 One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, dividend, divisor.
  - Outputs: next rem, next dividend with quotient bit inserted.
  - Instantiated once inside div_ctrl.

Verification
REQ-032 Unsigned 100/7, start at edge 0 -> done at edge 34, LO=14, HI=2, div0=0, busy high for 34 cycles.
REQ-033 Signed 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; the same operands unsigned -> LO=0x7FFFFFFC, HI=1.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div0=0.
REQ-035 B=0 with prior LO=5, HI=3 -> done=div0=1 one cycle after start, busy never high, LO=5, HI=3.
REQ-036 Abort cases:
  - flush at counter=10 -> IDLE next cycle, no done, HI/LO unchanged.
  - async reset pulse mid-ITER between clock edges -> outputs zero immediately.
  - New start after either abort completes normally.
REQ-037 start re-asserted during busy -> ignored; second start on the done cycle -> accepted, second done exactly 34 cycles later.
